// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the single-error-detect (SED) parity encoder/checker pair.
// Both stages use sed_parity so that they compute parity the same way.
package ecc_sed_pkg;

   localparam int DEF_DATA_W = 12;
   localparam int CW_W       = DEF_DATA_W + 1;
   localparam int SED_MAX_W  = 64;

   typedef struct packed {
      logic                  parity;
      logic [DEF_DATA_W-1:0] data;
   } codeword_t;

   // The caller zero-extends its vector to SED_MAX_W bits.
   // Zero bits do not change the XOR, so any width up to SED_MAX_W works.
   function automatic logic sed_parity(input logic [SED_MAX_W-1:0] vec);
      return ^vec;
   endfunction

endpackage

// File: rtl/ecc_sed_out_reg.sv
// One-deep valid/ready register stage.
// It holds its word while the consumer stalls, and it reloads on the same edge as a consume.
module ecc_sed_out_reg
   import ecc_sed_pkg::*;
#(
   parameter int W = CW_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         valid_reg;
   logic [W-1:0] data_reg;

   assign in_ready  = !valid_reg || out_ready;
   assign out_valid = valid_reg;
   assign out_data  = data_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (in_valid && in_ready) begin
         valid_reg <= 1'b1;
         data_reg  <= in_data;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/ecc_sed_checker.sv
// SED parity checker: registered payload plus error flag, sticky error status.
// Defining ECC_SED_ERR_CNT_EN adds the CNT_W parameter, the err_count port and the saturating error counter.
module ecc_sed_checker
   import ecc_sed_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
`ifdef ECC_SED_ERR_CNT_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enc_valid,
   output logic              enc_ready,
   input  logic [DATA_W:0]   enc_codeword,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [DATA_W-1:0] dec_data,
   output logic              dec_err,
   output logic              err_sticky,
`ifdef ECC_SED_ERR_CNT_EN
   output logic [CNT_W-1:0]  err_count,
`endif
   input  logic              err_clr
);

   logic          syndrome;
   logic          accept_err;
   logic          err_sticky_reg;
   logic [DATA_W:0] stage_in;
   logic [DATA_W:0] stage_out;

   assign syndrome   = sed_parity(SED_MAX_W'(enc_codeword));
   assign stage_in   = {syndrome, enc_codeword[DATA_W-1:0]};
   assign accept_err = enc_valid && enc_ready && syndrome;

   ecc_sed_out_reg #(.W(DATA_W + 1)) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (enc_valid),
      .in_ready  (enc_ready),
      .in_data   (stage_in),
      .out_valid (dec_valid),
      .out_ready (dec_ready),
      .out_data  (stage_out)
   );

   assign dec_err  = stage_out[DATA_W];
   assign dec_data = stage_out[DATA_W-1:0];

   // A new accepted error takes priority over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_sticky_reg <= 1'b0;
      end else if (accept_err) begin
         err_sticky_reg <= 1'b1;
      end else if (err_clr) begin
         err_sticky_reg <= 1'b0;
      end
   end

   assign err_sticky = err_sticky_reg;

`ifdef ECC_SED_ERR_CNT_EN
   logic [CNT_W-1:0] err_count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count_reg <= '0;
      end else if (accept_err) begin
         if (err_clr) begin
            err_count_reg <= CNT_W'(1);
         end else if (err_count_reg != {CNT_W{1'b1}}) begin
            err_count_reg <= err_count_reg + CNT_W'(1);
         end
      end else if (err_clr) begin
         err_count_reg <= '0;
      end
   end

   assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_ecc_sed_checker.sv
// Scoreboard bench for ecc_sed_checker: directed cases, then random traffic.
// The expected parity and status come from a bit-count model; the err_count checks need ECC_SED_ERR_CNT_EN.
module tb_ecc_sed_checker;

   localparam int DW      = 12;
   localparam int CW      = DW + 1;
   localparam int TB_CNT  = 4;
   localparam int CNT_MAX = (1 << TB_CNT) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          enc_valid;
   logic          enc_ready;
   logic [CW-1:0] enc_codeword;
   logic          dec_valid;
   logic          dec_ready;
   logic [DW-1:0] dec_data;
   logic          dec_err;
   logic          err_sticky;
   logic          err_clr;
`ifdef ECC_SED_ERR_CNT_EN
   logic [TB_CNT-1:0] err_count;
`endif

   always #5 clk = ~clk;

`ifdef ECC_SED_ERR_CNT_EN
   ecc_sed_checker #(.DATA_W(DW), .CNT_W(TB_CNT)) dut (
`else
   ecc_sed_checker #(.DATA_W(DW)) dut (
`endif
      .clk          (clk),
      .rst          (rst),
      .enc_valid    (enc_valid),
      .enc_ready    (enc_ready),
      .enc_codeword (enc_codeword),
      .dec_valid    (dec_valid),
      .dec_ready    (dec_ready),
      .dec_data     (dec_data),
      .dec_err      (dec_err),
      .err_sticky   (err_sticky),
`ifdef ECC_SED_ERR_CNT_EN
      .err_count    (err_count),
`endif
      .err_clr      (err_clr)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   m_sticky = 1'b0;
   int   m_count  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_status();
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
`ifdef ECC_SED_ERR_CNT_EN
      chk("err_count", 32'(err_count), 32'(m_count));
`endif
   endtask

   // One clock cycle. It checks the status left by the previous edge, drives the inputs,
   // and then models the edge that comes next.
   task automatic cycle(input bit v, input logic [CW-1:0] cw, input bit rdy, input bit clr);
      bit err;
      exp_t e;
      @(negedge clk);
      check_status();
      enc_valid    = v;
      enc_codeword = cw;
      dec_ready    = rdy;
      err_clr      = clr;
      #1;
      chk("enc_ready", 32'(enc_ready), 32'(!dec_valid || rdy));
      err = ($countones(cw) % 2) == 1;
      if (v && enc_ready) begin
         e.data = cw[DW-1:0];
         e.err  = err;
         q.push_back(e);
         $display("txn cw=%h data=%h err=%0d clr=%0d", cw, e.data, err, clr);
      end
      if (v && enc_ready && err) begin
         m_sticky = 1'b1;
         m_count  = clr ? 1 : ((m_count < CNT_MAX) ? m_count + 1 : m_count);
      end else if (clr) begin
         m_sticky = 1'b0;
         m_count  = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      enc_valid = 1'b0;
      err_clr   = 1'b0;
      #1;
      q.delete();
      m_sticky = 1'b0;
      m_count  = 0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_dec_data", 32'(dec_data), 32'd0);
      chk("rst_dec_err", 32'(dec_err), 32'd0);
      check_status();
   endtask

   // Monitor: pops and compares whenever the output handshake completes on the next edge.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rst && dec_valid && dec_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 32'(dec_data), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("dec_data", 32'(dec_data), 32'(e.data));
               chk("dec_err", 32'(dec_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      rst          = 1'b1;
      enc_valid    = 1'b0;
      enc_codeword = '0;
      dec_ready    = 1'b1;
      err_clr      = 1'b0;
      do_reset();

      // Clean word, single-bit error, even-weight word.
      cycle(1'b1, 13'h0A5C, 1'b1, 1'b0);
      cycle(1'b1, 13'h0A54, 1'b1, 1'b0);
      cycle(1'b1, 13'h1001, 1'b1, 1'b0);
      cycle(1'b0, 13'h0000, 1'b1, 1'b0);

      // Stall: the held word must survive, and the presented word must wait.
      cycle(1'b1, 13'h0ABC, 1'b0, 1'b0);
      cycle(1'b1, 13'h0003, 1'b0, 1'b0);
      chk("stall_enc_ready", 32'(enc_ready), 32'd0);
      cycle(1'b1, 13'h0003, 1'b0, 1'b0);
      chk("stall_hold_data", 32'(dec_data), 32'h0ABC);
      cycle(1'b1, 13'h0003, 1'b1, 1'b0);
      cycle(1'b0, 13'h0000, 1'b1, 1'b0);

      // Back-to-back errored words: the counter saturates and the stream runs without bubbles.
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 13'h0001, 1'b1, 1'b0);
         if (i > 0) chk("stream_valid", 32'(dec_valid), 32'd1);
      end
      cycle(1'b0, 13'h0000, 1'b1, 1'b0);

      // Clear together with an error, then a clear on its own.
      cycle(1'b1, 13'h0002, 1'b1, 1'b1);
      cycle(1'b0, 13'h0000, 1'b1, 1'b1);
      cycle(1'b1, 13'h0007, 1'b1, 1'b0);
      cycle(1'b0, 13'h0000, 1'b1, 1'b0);

      // Reset while a stalled word is held.
      cycle(1'b1, 13'h0011, 1'b0, 1'b0);
      cycle(1'b1, 13'h0001, 1'b0, 1'b0);
      do_reset();

      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 3) != 0), CW'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 15) == 0));
      end

      for (int i = 0; i < 3; i++) cycle(1'b0, 13'h0000, 1'b1, 1'b0);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
